// File: rtl/fst_cpu.sv
// Single-cycle 16-bit SIMPLE processor core: fetch, decode, execute and writeback
// all complete in one clock, with a RUN/HALT state that freezes every register once HLT executes.
module fst_cpu (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] inst_mem_adr,
    input  logic [15:0] inst,
    output logic [15:0] main_mem_read_adr,
    input  logic [15:0] main_mem_dat,
    output logic        main_mem_write,
    output logic [15:0] main_mem_write_adr,
    output logic [15:0] main_mem_write_dat,
    input  logic [15:0] in_dat,
    output logic        out_en,
    output logic [15:0] out_dat,
    output logic        is_halt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } run_state_e;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_CMP = 4'b0101;
    localparam logic [3:0] OP_MOV = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SLR = 4'b1001;
    localparam logic [3:0] OP_SRL = 4'b1010;
    localparam logic [3:0] OP_SRA = 4'b1011;
    localparam logic [3:0] OP_IN  = 4'b1100;
    localparam logic [3:0] OP_OUT = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [1:0] CLS_LD  = 2'b00;
    localparam logic [1:0] CLS_ST  = 2'b01;
    localparam logic [1:0] CLS_IMM = 2'b10;
    localparam logic [1:0] CLS_ALU = 2'b11;

    // Architectural state
    run_state_e  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] rf_q [0:7];
    logic        flag_s_q, flag_z_q, flag_c_q, flag_v_q;
    logic        flag_s_d, flag_z_d, flag_c_d, flag_v_d;
    logic        out_en_q, out_en_d;
    logic [15:0] out_dat_q, out_dat_d;

    // Register-file write port
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;

    // Instruction fields
    logic [1:0]  cls;
    logic [2:0]  fa;
    logic [2:0]  fb;
    logic [3:0]  op3;
    logic [3:0]  sh;
    logic [7:0]  d8;
    logic [15:0] imm;

    assign cls = inst[15:14];
    assign fa  = inst[13:11];
    assign fb  = inst[10:8];
    assign op3 = inst[7:4];
    assign sh  = inst[3:0];
    assign d8  = inst[7:0];
    assign imm = {{8{d8[7]}}, d8};

    // Operand and address datapath
    logic [15:0] rs_val, rd_val, mem_adr, pc_inc, br_target;

    assign rs_val    = rf_q[fa];
    assign rd_val    = rf_q[fb];
    assign mem_adr   = rd_val + imm;
    assign pc_inc    = pc_q + 16'd1;
    assign br_target = pc_inc + imm;

    // Shifters are one bit wider so the last bit moved out lands in the extra bit.
    logic [16:0] add_w, sll_w, srl_w, sra_w;
    logic [15:0] sub_w, rol_w;
    logic [4:0]  rol_back;

    assign add_w    = {1'b0, rd_val} + {1'b0, rs_val};
    assign sub_w    = rd_val - rs_val;
    assign sll_w    = {1'b0, rd_val} << sh;
    assign srl_w    = {rd_val, 1'b0} >> sh;
    assign sra_w    = $signed({rd_val, 1'b0}) >>> sh;
    assign rol_back = 5'd16 - {1'b0, sh};
    assign rol_w    = (rd_val << sh) | (rd_val >> rol_back);

    logic [15:0] alu_res;
    logic        alu_c, alu_v;
    logic        alu_flags_we, alu_res_we;

    always_comb begin
        alu_res      = 16'h0000;
        alu_c        = 1'b0;
        alu_v        = 1'b0;
        alu_flags_we = 1'b1;
        alu_res_we   = 1'b1;
        unique case (op3)
            OP_ADD: begin
                alu_res = add_w[15:0];
                alu_c   = add_w[16];
                alu_v   = (rd_val[15] == rs_val[15]) && (add_w[15] != rd_val[15]);
            end
            OP_SUB, OP_CMP: begin
                alu_res    = sub_w;
                alu_c      = rd_val < rs_val;
                alu_v      = (rd_val[15] != rs_val[15]) && (sub_w[15] != rd_val[15]);
                alu_res_we = (op3 == OP_SUB);
            end
            OP_AND: alu_res = rd_val & rs_val;
            OP_OR:  alu_res = rd_val | rs_val;
            OP_XOR: alu_res = rd_val ^ rs_val;
            OP_MOV: alu_res = rs_val;
            OP_SLL: begin
                alu_res = sll_w[15:0];
                alu_c   = sll_w[16];
            end
            OP_SLR: begin
                alu_res = rol_w;
                alu_c   = (sh != 4'd0) && rol_w[0];
            end
            OP_SRL: begin
                alu_res = srl_w[16:1];
                alu_c   = srl_w[0];
            end
            OP_SRA: begin
                alu_res = sra_w[16:1];
                alu_c   = sra_w[0];
            end
            default: begin
                alu_flags_we = 1'b0;
                alu_res_we   = 1'b0;
            end
        endcase
    end

    logic br_cond;

    always_comb begin
        br_cond = 1'b0;
        unique case (fb)
            3'b000:  br_cond = flag_z_q;
            3'b001:  br_cond = flag_s_q ^ flag_v_q;
            3'b010:  br_cond = flag_z_q | (flag_s_q ^ flag_v_q);
            3'b011:  br_cond = !flag_z_q;
            default: br_cond = 1'b0;
        endcase
    end

    // Next-state: everything holds while halted.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rf_we     = 1'b0;
        rf_waddr  = fb;
        rf_wdata  = alu_res;
        flag_s_d  = flag_s_q;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
        flag_v_d  = flag_v_q;
        out_en_d  = 1'b0;
        out_dat_d = out_dat_q;

        if (state_q == ST_RUN) begin
            pc_d = pc_inc;
            unique case (cls)
                CLS_LD: begin
                    rf_we    = 1'b1;
                    rf_waddr = fa;
                    rf_wdata = main_mem_dat;
                end
                CLS_ST: begin
                    rf_we = 1'b0;
                end
                CLS_IMM: begin
                    if (fa == 3'b000) begin
                        rf_we    = 1'b1;
                        rf_wdata = imm;
                    end else if (fa == 3'b100) begin
                        pc_d = br_target;
                    end else if (fa == 3'b111 && br_cond) begin
                        pc_d = br_target;
                    end
                end
                CLS_ALU: begin
                    rf_we = alu_res_we;
                    if (alu_flags_we) begin
                        flag_s_d = alu_res[15];
                        flag_z_d = (alu_res == 16'h0000);
                        flag_c_d = alu_c;
                        flag_v_d = alu_v;
                    end
                    if (op3 == OP_IN) begin
                        rf_we    = 1'b1;
                        rf_wdata = in_dat;
                    end
                    if (op3 == OP_OUT) begin
                        out_en_d  = 1'b1;
                        out_dat_d = rs_val;
                    end
                    if (op3 == OP_HLT) begin
                        state_d = ST_HALT;
                        pc_d    = pc_q;
                    end
                end
                default: rf_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            pc_q      <= 16'h0000;
            flag_s_q  <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            flag_v_q  <= 1'b0;
            out_en_q  <= 1'b0;
            out_dat_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            flag_s_q  <= flag_s_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
            flag_v_q  <= flag_v_d;
            out_en_q  <= out_en_d;
            out_dat_q <= out_dat_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 16'h0000;
            end
        end else if (rf_we) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    // The store strobe is combinational so an asserted reset kills it within the cycle.
    assign main_mem_write     = (cls == CLS_ST) && (state_q == ST_RUN) && reset;
    assign main_mem_write_adr = mem_adr;
    assign main_mem_write_dat = rs_val;
    assign main_mem_read_adr  = mem_adr;
    assign inst_mem_adr       = pc_q;
    assign out_en             = out_en_q;
    assign out_dat            = out_dat_q;
    assign is_halt            = (state_q == ST_HALT);

endmodule

// File: tb/tb_fst_cpu.sv
// Directed bench for fst_cpu: small programs run from a bench-side ROM/RAM, with
// expected OUT values and store transactions scoreboarded against the port activity.
module tb_fst_cpu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] inst_mem_adr, inst, main_mem_read_adr, main_mem_dat;
    logic        main_mem_write;
    logic [15:0] main_mem_write_adr, main_mem_write_dat;
    logic [15:0] in_dat = 16'h0000;
    logic        out_en, is_halt;
    logic [15:0] out_dat;

    fst_cpu dut (
        .clk                (clk),
        .reset              (reset),
        .inst_mem_adr       (inst_mem_adr),
        .inst               (inst),
        .main_mem_read_adr  (main_mem_read_adr),
        .main_mem_dat       (main_mem_dat),
        .main_mem_write     (main_mem_write),
        .main_mem_write_adr (main_mem_write_adr),
        .main_mem_write_dat (main_mem_write_dat),
        .in_dat             (in_dat),
        .out_en             (out_en),
        .out_dat            (out_dat),
        .is_halt            (is_halt)
    );

    // Clock and memories
    always #5 clk = ~clk;

    logic [15:0] rom [0:255];
    logic [15:0] ram [0:255];
    logic        ram_clear = 1'b0;

    assign inst         = rom[inst_mem_adr[7:0]];
    assign main_mem_dat = ram[main_mem_read_adr[7:0]];

    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 256; i++) ram[i] <= 16'h0000;
        end else if (main_mem_write) begin
            ram[main_mem_write_adr[7:0]] <= main_mem_write_dat;
        end
    end

    // Scoreboard
    logic [15:0] exp_q [$];
    logic [31:0] exp_wq [$];
    logic        wr_track = 1'b1;
    int          n_total = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && out_en) begin
            if (exp_q.size() == 0) check("out_unexpected", {31'b0, out_en}, 32'h0);
            else check("out_dat", {16'h0, out_dat}, {16'h0, exp_q.pop_front()});
        end
        if (reset && main_mem_write && wr_track) begin
            if (exp_wq.size() == 0) check("wr_unexpected", {31'b0, main_mem_write}, 32'h0);
            else check("wr_adr_dat", {main_mem_write_adr, main_mem_write_dat}, exp_wq.pop_front());
        end
    end

    // Instruction encoders
    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, OR_ = 4'b0011, CMP = 4'b0101;
    localparam logic [3:0] SLL = 4'b1000, SLR = 4'b1001, SRL = 4'b1010, SRA = 4'b1011;
    localparam logic [3:0] IN_ = 4'b1100, OUT = 4'b1101, HLT = 4'b1111, NOP = 4'b0111;

    function automatic logic [15:0] alu(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [3:0] d);
        return {2'b11, rs, rd, op, d};
    endfunction
    function automatic logic [15:0] li(input logic [2:0] rb, input logic [7:0] v);
        return {2'b10, 3'b000, rb, v};
    endfunction
    function automatic logic [15:0] ld(input logic [2:0] ra, input logic [2:0] rb, input logic [7:0] o);
        return {2'b00, ra, rb, o};
    endfunction
    function automatic logic [15:0] st(input logic [2:0] ra, input logic [2:0] rb, input logic [7:0] o);
        return {2'b01, ra, rb, o};
    endfunction
    function automatic logic [15:0] bra(input logic [7:0] o);
        return {2'b10, 3'b100, 3'b000, o};
    endfunction
    function automatic logic [15:0] bcc(input logic [2:0] cond, input logic [7:0] o);
        return {2'b10, 3'b111, cond, o};
    endfunction

    // Driver tasks
    task automatic begin_load();
        reset = 1'b0;
        ram_clear = 1'b1;
        wr_track = 1'b1;
        for (int i = 0; i < 256; i++) rom[i] = alu(NOP, 3'd0, 3'd0, 4'd0);
        repeat (2) @(negedge clk);
        ram_clear = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_to_halt(input int budget);
        int k;
        k = 0;
        while (!is_halt && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("halt_reached", {31'b0, is_halt}, 32'h1);
    endtask

    task automatic drained();
        check("outq_left", exp_q.size(), 32'h0);
        check("wrq_left", exp_wq.size(), 32'h0);
    endtask

    logic [15:0] pc_snap;

    initial begin
        // Program 1: LI/ADD/OUT/HLT, reset state, halt freeze, async reset out of halt
        begin_load();
        #1;
        check("rst_pc", {16'h0, inst_mem_adr}, 32'h0);
        check("rst_halt", {31'b0, is_halt}, 32'h0);
        check("rst_out_en", {31'b0, out_en}, 32'h0);
        check("rst_out_dat", {16'h0, out_dat}, 32'h0);
        check("rst_wr", {31'b0, main_mem_write}, 32'h0);
        rom[0] = li(3'd1, 8'd5);
        rom[1] = li(3'd2, 8'hFD);
        rom[2] = alu(ADD, 3'd1, 3'd2, 4'd0);
        rom[3] = alu(OUT, 3'd0, 3'd1, 4'd0);
        rom[4] = alu(HLT, 3'd0, 3'd0, 4'd0);
        exp_q.push_back(16'h0002);
        release_reset();
        check("first_pc", {16'h0, inst_mem_adr}, 32'h0);
        step(1);
        check("pc_after_1", {16'h0, inst_mem_adr}, 32'h1);
        run_to_halt(40);
        pc_snap = inst_mem_adr;
        step(4);
        check("pc_frozen", {16'h0, inst_mem_adr}, {16'h0, pc_snap});
        check("halt_out_dat", {16'h0, out_dat}, 32'h2);
        check("halt_out_en", {31'b0, out_en}, 32'h0);
        drained();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_halt", {31'b0, is_halt}, 32'h0);
        check("mid_rst_pc", {16'h0, inst_mem_adr}, 32'h0);

        // Program 2: store then load-back of the same address
        begin_load();
        rom[0] = li(3'd0, 8'h7F);
        rom[1] = li(3'd3, 8'd10);
        rom[2] = st(3'd0, 3'd3, 8'd2);
        rom[3] = ld(3'd4, 3'd3, 8'd2);
        rom[4] = alu(OUT, 3'd0, 3'd4, 4'd0);
        rom[5] = alu(HLT, 3'd0, 3'd0, 4'd0);
        exp_wq.push_back({16'd12, 16'h007F});
        exp_q.push_back(16'h007F);
        release_reset();
        run_to_halt(40);
        check("ram12", {16'h0, ram[12]}, 32'h007F);
        drained();

        // Program 3: countdown loop with BNE, r6 counts loop passes
        begin_load();
        rom[0] = li(3'd1, 8'd3);
        rom[1] = li(3'd2, 8'd1);
        rom[2] = li(3'd6, 8'd0);
        rom[3] = alu(ADD, 3'd6, 3'd2, 4'd0);
        rom[4] = alu(SUB, 3'd1, 3'd2, 4'd0);
        rom[5] = bcc(3'b011, 8'hFD);
        rom[6] = alu(OUT, 3'd0, 3'd1, 4'd0);
        rom[7] = alu(OUT, 3'd0, 3'd6, 4'd0);
        rom[8] = alu(HLT, 3'd0, 3'd0, 4'd0);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0003);
        release_reset();
        run_to_halt(60);
        check("loop_z", {31'b0, dut.flag_z_q}, 32'h1);
        drained();

        // Program 4: shifts and rotate with carry-out
        begin_load();
        rom[0]  = li(3'd1, 8'h80);
        rom[1]  = alu(SRA, 3'd1, 3'd0, 4'd4);
        rom[2]  = alu(OUT, 3'd0, 3'd1, 4'd0);
        rom[3]  = li(3'd2, 8'd1);
        rom[4]  = li(3'd3, 8'd1);
        rom[5]  = alu(SLL, 3'd3, 3'd0, 4'd15);
        rom[6]  = alu(OR_, 3'd2, 3'd3, 4'd0);
        rom[7]  = alu(SLR, 3'd2, 3'd0, 4'd1);
        rom[8]  = alu(OUT, 3'd0, 3'd2, 4'd0);
        rom[9]  = alu(SRL, 3'd3, 3'd0, 4'd15);
        rom[10] = alu(OUT, 3'd0, 3'd3, 4'd0);
        rom[11] = alu(HLT, 3'd0, 3'd0, 4'd0);
        exp_q.push_back(16'hFFF8);
        exp_q.push_back(16'h0003);
        exp_q.push_back(16'h0001);
        release_reset();
        step(2);
        check("sra_c", {31'b0, dut.flag_c_q}, 32'h0);
        step(6);
        check("slr_c", {31'b0, dut.flag_c_q}, 32'h1);
        run_to_halt(40);
        check("srl_c", {31'b0, dut.flag_c_q}, 32'h0);
        check("srl_z", {31'b0, dut.flag_z_q}, 32'h0);
        drained();

        // Program 5: signed compare and BLT both ways
        begin_load();
        rom[0]  = li(3'd1, 8'd1);
        rom[1]  = alu(SLL, 3'd1, 3'd0, 4'd15);
        rom[2]  = li(3'd2, 8'd1);
        rom[3]  = alu(SUB, 3'd1, 3'd2, 4'd0);
        rom[4]  = li(3'd3, 8'hFF);
        rom[5]  = alu(CMP, 3'd1, 3'd3, 4'd0);
        rom[6]  = bcc(3'b001, 8'd1);
        rom[7]  = alu(OUT, 3'd0, 3'd2, 4'd0);
        rom[8]  = li(3'd4, 8'd1);
        rom[9]  = li(3'd5, 8'd2);
        rom[10] = alu(CMP, 3'd4, 3'd5, 4'd0);
        rom[11] = bcc(3'b001, 8'd1);
        rom[12] = alu(OUT, 3'd0, 3'd3, 4'd0);
        rom[13] = alu(OUT, 3'd0, 3'd1, 4'd0);
        rom[14] = alu(HLT, 3'd0, 3'd0, 4'd0);
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h7FFF);
        release_reset();
        run_to_halt(60);
        drained();

        // Program 6: IN/OUT, then reset asserted during a store cycle
        begin_load();
        in_dat = 16'h1234;
        rom[0] = alu(IN_, 3'd5, 3'd0, 4'd0);
        rom[1] = alu(OUT, 3'd0, 3'd5, 4'd0);
        rom[2] = st(3'd5, 3'd0, 8'h20);
        rom[3] = bra(8'hFE);
        exp_q.push_back(16'h1234);
        wr_track = 1'b0;
        release_reset();
        begin
            int k;
            k = 0;
            while (inst_mem_adr != 16'd2 && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        check("st_pc", {16'h0, inst_mem_adr}, 32'h2);
        check("st_strobe", {31'b0, main_mem_write}, 32'h1);
        check("st_adr_dat", {main_mem_write_adr, main_mem_write_dat}, {16'h0020, 16'h1234});
        #2 reset = 1'b0;
        #1;
        check("abort_pc", {16'h0, inst_mem_adr}, 32'h0);
        check("abort_wr", {31'b0, main_mem_write}, 32'h0);
        check("abort_halt", {31'b0, is_halt}, 32'h0);
        check("abort_out_dat", {16'h0, out_dat}, 32'h0);
        step(1);
        check("abort_no_store", {16'h0, ram[8'h20]}, 32'h0);
        drained();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
